// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way request arbiter.
// Imported by the priority picker and the arbiter top.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam logic [ID_W-1:0] RR_PTR_INIT = 3'd7;

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational 8-way pick: scans downward from start_id-1 with wrap.
// A start of 0 makes the scan 7..0, i.e. plain highest-index-first.
module rr_prio_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    start_id,
  input  logic               rr_en,
  output logic [ID_W-1:0]    win_id,
  output logic               any
);

  logic [ID_W-1:0] base;
  logic [ID_W-1:0] idx;

  always_comb begin
    base   = rr_en ? start_id : '0;
    idx    = '0;
    win_id = '0;
    any    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = base - ID_W'(k);
      if (!any && req[idx]) begin
        win_id = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arbiter_8.sv
// Grant-holding arbiter for 8 requesters with fixed or rotating priority.
// A grant lasts until release, request drop, or the hold-time limit.
module req_arbiter_8
  import arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 0,
  parameter int MAX_HOLD    = 16,
  parameter int HOLD_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam logic RR_EN = (ROUND_ROBIN != 0);
  localparam logic HOLD_ON = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LIM =
    HOLD_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               valid_q, valid_d;
  logic               to_q, to_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [ID_W-1:0]    last_q, last_d;

  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  logic               hold_hit;

  rr_prio_pick u_pick (
    .req      (req),
    .start_id (last_q),
    .rr_en    (RR_EN),
    .win_id   (pick_id),
    .any      (pick_any)
  );

  assign hold_hit = HOLD_ON && (hold_q == HOLD_LIM);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    hold_d  = hold_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = NUM_REQ'(1) << pick_id;
          id_d    = pick_id;
          valid_d = 1'b1;
          hold_d  = '0;
          last_d  = pick_id;
        end
      end
      GRANT: begin
        // request drop and done outrank the hold limit
        if (!req[id_q] || done || hold_hit) begin
          state_d = IDLE;
          gnt_d   = '0;
          id_d    = '0;
          valid_d = 1'b0;
          to_d    = req[id_q] && !done;
        end else if (HOLD_ON) begin
          hold_d = hold_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      hold_q  <= '0;
      last_q  <= RR_PTR_INIT;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = valid_q;
  assign timeout   = to_q;

endmodule
